// File: rtl/fp32_pkg.sv
// ============================================================================
// Module : fp32_pkg
// Brief  : Shared FSM encodings and IEEE-754 single-precision constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam int          MANT_W   = 24;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] ZERO     = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fp32_round_rne.sv
// ============================================================================
// Module : fp32_round_rne
// Brief  : Combinational round-to-nearest-even increment of a 24-bit mantissa.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [MANT_W-1:0] m,
    input  logic              g,
    input  logic              r,
    input  logic              s,
    output logic [MANT_W-1:0] m_rnd,
    output logic              carry
);

    logic w_inc;

    // Round up above half, or exactly half when the kept LSB is odd.
    assign w_inc          = g & (r | s | m[0]);
    assign {carry, m_rnd} = {1'b0, m} + {{MANT_W{1'b0}}, w_inc};

endmodule

`default_nettype wire

// File: rtl/fp32_norm_round.sv
// ============================================================================
// Module : fp32_norm_round
// Brief  : Post-add normalise and RNE round to packed IEEE-754 single.
//          Define FP32_NORM_DENORM_EN to emit subnormals instead of flushing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_norm_round
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [23:0] in_mant,
    input  logic        in_cy,
    input  logic        in_ope,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_zero
);

    state_t             r_state, w_state_nxt;
    logic [8:0]         r_e;
    logic [MANT_W-1:0]  r_m;
    logic               r_g, r_r, r_s;
    logic               r_sign, r_cy, r_ope, r_first;
    logic [31:0]        r_result;
    logic               r_ovf, r_zero;

    logic               w_carry_step, w_is_zero, w_shift;
    logic [MANT_W-1:0]  w_m_rnd, w_m_fin;
    logic               w_rnd_carry;
    logic [8:0]         w_e_rnd;
    logic [31:0]        w_result;
    logic               w_ovf, w_zero;

    assign w_carry_step = r_first & r_cy;
    assign w_is_zero    = (r_m == '0) & ~(r_g | r_r | r_s);
    assign w_shift      = ~r_m[MANT_W-1] & (r_e > 9'd1);

    fp32_round_rne u_round (
        .m     (r_m),
        .g     (r_g),
        .r     (r_r),
        .s     (r_s),
        .m_rnd (w_m_rnd),
        .carry (w_rnd_carry)
    );

    assign w_m_fin = w_rnd_carry ? {1'b1, {(MANT_W-1){1'b0}}} : w_m_rnd;
    assign w_e_rnd = r_e + {8'd0, w_rnd_carry};

    always_comb begin
        w_ovf    = 1'b0;
        w_zero   = 1'b0;
        w_result = {r_sign, w_e_rnd[7:0], w_m_fin[22:0]};
        if (w_e_rnd >= 9'(EXP_MAX)) begin
            w_result = {r_sign, POS_INF[30:0]};
            w_ovf    = 1'b1;
        end else if (!w_m_fin[MANT_W-1]) begin
`ifdef FP32_NORM_DENORM_EN
            w_result = {r_sign, 8'h00, w_m_fin[22:0]};
            w_zero   = (w_m_fin == '0);
`else
            w_result = {r_sign, ZERO[30:0]};
            w_zero   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_NORM;
            S_NORM: begin
                if (w_carry_step)   w_state_nxt = S_NORM;
                else if (w_is_zero) w_state_nxt = S_DONE;
                else if (w_shift)   w_state_nxt = S_NORM;
                else                w_state_nxt = S_ROUND;
            end
            S_ROUND: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e      <= '0;
            r_m      <= '0;
            r_g      <= 1'b0;
            r_r      <= 1'b0;
            r_s      <= 1'b0;
            r_sign   <= 1'b0;
            r_cy     <= 1'b0;
            r_ope    <= 1'b0;
            r_first  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_sign  <= in_sign;
                    r_e     <= {1'b0, in_exp};
                    r_m     <= in_mant;
                    {r_g, r_r, r_s} <= in_grs;
                    r_cy    <= in_cy;
                    r_ope   <= in_ope;
                    r_first <= 1'b1;
                end
                S_NORM: begin
                    r_first <= 1'b0;
                    if (w_carry_step) begin
                        r_m <= {1'b1, r_m[MANT_W-1:1]};
                        r_g <= r_m[0];
                        r_r <= r_g;
                        r_s <= r_r | r_s;
                        r_e <= r_e + 9'd1;
                    end else if (w_is_zero) begin
                        // Exact cancellation yields +0; a true zero sum keeps its sign.
                        r_result <= {~r_ope & r_sign, ZERO[30:0]};
                        r_ovf    <= 1'b0;
                        r_zero   <= 1'b1;
                    end else if (w_shift) begin
                        r_m <= {r_m[MANT_W-2:0], r_g};
                        r_g <= r_r;
                        r_r <= 1'b0;
                        r_e <= r_e - 9'd1;
                    end
                end
                S_ROUND: begin
                    r_result <= w_result;
                    r_ovf    <= w_ovf;
                    r_zero   <= w_zero;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_ovf    = r_ovf;
    assign out_zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_fp32_norm_round.sv
// ============================================================================
// Module : tb_fp32_norm_round
// Brief  : Directed vector bench for fp32_norm_round (value, flags, latency).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign, in_cy, in_ope;
    logic [7:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid, out_ready, out_ovf, out_zero;
    logic [31:0] out_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp32_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_cy      (in_cy),
        .in_ope     (in_ope),
        .in_grs     (in_grs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        cy;
        logic        ope;
        logic [2:0]  grs;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Accepts one operand and returns the number of cycles until out_valid.
    task automatic launch(input vec_t v, output int lat);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_cy    = v.cy;
        in_ope   = v.ope;
        in_grs   = v.grs;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic check_result(input string name, input vec_t v, input int lat);
        check({name, "_lat"},    lat, v.lat);
        check({name, "_result"}, out_result, v.res);
        check({name, "_ovf"},    {31'd0, out_ovf}, {31'd0, v.ovf});
        check({name, "_zero"},   {31'd0, out_zero}, {31'd0, v.zero});
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("ack_to_idle", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int   lat;
        logic [31:0] held;

`ifdef FP32_NORM_DENORM_EN
        vecs[6]  = '{1'b0, 8'd1,   24'h400000, 1'b0, 1'b0, 3'b000, 32'h0040_0000, 1'b0, 1'b0, 2};
        vecs[12] = '{1'b0, 8'd3,   24'h100000, 1'b0, 1'b1, 3'b000, 32'h0040_0000, 1'b0, 1'b0, 4};
`else
        vecs[6]  = '{1'b0, 8'd1,   24'h400000, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[12] = '{1'b0, 8'd3,   24'h100000, 1'b0, 1'b1, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 4};
`endif
        vecs[0]  = '{1'b0, 8'd127, 24'h800000, 1'b1, 1'b0, 3'b000, 32'h4040_0000, 1'b0, 1'b0, 3};
        vecs[1]  = '{1'b1, 8'd127, 24'h000000, 1'b0, 1'b1, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[2]  = '{1'b0, 8'd127, 24'h000001, 1'b0, 1'b1, 3'b000, 32'h3400_0000, 1'b0, 1'b0, 25};
        vecs[3]  = '{1'b0, 8'd127, 24'h800001, 1'b0, 1'b0, 3'b100, 32'h3F80_0002, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 3'b100, 32'h3F80_0000, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b0, 8'd254, 24'hFFFFFF, 1'b0, 1'b0, 3'b110, 32'h7F80_0000, 1'b1, 1'b0, 2};
        vecs[7]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 3'b110, 32'h3F80_0001, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b0, 8'd127, 24'hFFFFFF, 1'b0, 1'b0, 3'b100, 32'h4000_0000, 1'b0, 1'b0, 2};
        vecs[9]  = '{1'b0, 8'd127, 24'h800003, 1'b1, 1'b0, 3'b000, 32'h4040_0002, 1'b0, 1'b0, 3};
        vecs[10] = '{1'b1, 8'd130, 24'h900000, 1'b0, 1'b0, 3'b000, 32'hC110_0000, 1'b0, 1'b0, 2};
        vecs[11] = '{1'b0, 8'd10,  24'h400000, 1'b0, 1'b1, 3'b100, 32'h0480_0001, 1'b0, 1'b0, 3};
        vecs[13] = '{1'b0, 8'd1,   24'h7FFFFF, 1'b0, 1'b0, 3'b110, 32'h0080_0000, 1'b0, 1'b0, 2};
        vecs[14] = '{1'b1, 8'd127, 24'h000000, 1'b0, 1'b0, 3'b000, 32'h8000_0000, 1'b0, 1'b1, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0; in_cy = 1'b0; in_ope = 1'b0; in_grs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
        check("reset_result", out_result, 32'd0);
        check("reset_flags", {30'd0, out_ovf, out_zero}, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            launch(vecs[i], lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            ack();
        end

        // Overflow result held under back-pressure, with in_valid pushing.
        launch(vecs[5], lat);
        check_result("hold", vecs[5], lat);
        held = out_result;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
            check("hold_result", out_result, held);
            check("hold_ovf", {31'd0, out_ovf}, 32'd1);
        end
        in_valid = 1'b0;
        ack();

        // Reset in the middle of a long normalising shift.
        launch(vecs[2], lat);
        ack();
        @(negedge clk);
        in_valid = 1'b1; in_mant = 24'h000001; in_exp = 8'd127; in_ope = 1'b1;
        in_cy = 1'b0; in_grs = 3'b000; in_sign = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
        check("midrst_result", out_result, 32'd0);
        check("midrst_flags", {30'd0, out_ovf, out_zero}, 32'd0);
        @(negedge clk) rst = 1'b0;
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1 if (out_valid) lat++;
        end
        check("midrst_no_valid", lat, 0);

        launch(vecs[3], lat);
        check_result("after_rst", vecs[3], lat);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
